// File: rtl/zx_ps2_keyboard.sv
// PS/2 set-2 keyboard front end: frame receiver, held-key decoder, ZX 8x5 matrix, Fn/modifier levels.
// Latency: 2 clk_sys cycles from the detected stop-bit edge to key_data / Fn / mod.
// Backpressure: none; PS/2 frames cannot be throttled, and bytes are consumed on the cycle they arrive.
//
// Ports:
//   clk_sys, reset_n      system clock, async active-low reset (released synchronously)
//   ps2_kbd_clk/_data     raw asynchronous PS/2 lines
//   addr[15:8]            active-low half-row selects for port FE reads
//   key_data[4:0]         active-low column read, bit0 = outermost key
//   Fn[11:1]              function-key levels
//   mod[2:0]              {shift, alt, ctrl} levels
module zx_ps2_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [4:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);

  localparam int FW    = $clog2(FILTER + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int NKEYS = 60;

  // Key ids 0..39 are matrix positions (row*5 + column); the rest are
  // keys that only feed composites, Fn or mod.
  localparam int K_CS    = 0;
  localparam int K_SS    = 36;
  localparam int K_BS    = 40;
  localparam int K_LEFT  = 41;
  localparam int K_DOWN  = 42;
  localparam int K_UP    = 43;
  localparam int K_RIGHT = 44;
  localparam int K_F1    = 45;
  localparam int K_LCTRL = 56;
  localparam int K_RCTRL = 57;
  localparam int K_LALT  = 58;
  localparam int K_RALT  = 59;

  // Reset: asserted asynchronously, released on a clock edge.
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_q <= 2'b00;
    else          rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  // Input synchronisers; lines idle high.
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_kbd_clk};
      dat_sync <= {dat_sync[0], ps2_kbd_data};
    end
  end

  // Glitch filter: the filtered clock only follows the synchronised line
  // after FILTER consecutive samples that disagree with it.
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          fall;
  logic          dat;

  assign filt_flip = (clk_sync[1] != clk_filt) && (filt_cnt == FW'(FILTER - 1));
  assign fall      = filt_flip & clk_filt;
  assign dat       = dat_sync[1];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Frame receiver
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  rx_state_t     state, state_next;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          byte_valid;
  logic          start_en, shift_en, par_en, frame_ok;

  assign timeout = (tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_en   = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_ok   = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat) begin
            state_next = DATA;
            start_en   = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_en     = 1'b1;
          state_next = STOP;
        end
        STOP: begin
          // odd parity: data byte plus parity bit carry an odd number of ones
          frame_ok   = dat & (^{par_bit, shreg});
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && timeout) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= frame_ok;
      if (start_en) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {dat, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en) par_bit <= dat;
      if (fall || state == IDLE) tcnt <= '0;
      else if (!timeout)         tcnt <= tcnt + 1'b1;
    end
  end

  // Scan code {ext, code} -> {hit, key id}
  function automatic logic [6:0] key_lookup(input logic [8:0] sc);
    logic       hit;
    logic [5:0] id;
    hit = 1'b1;
    id  = '0;
    case (sc)
      9'h012: id = 6'd0;   9'h01A: id = 6'd1;   9'h022: id = 6'd2;   9'h021: id = 6'd3;   9'h02A: id = 6'd4;
      9'h01C: id = 6'd5;   9'h01B: id = 6'd6;   9'h023: id = 6'd7;   9'h02B: id = 6'd8;   9'h034: id = 6'd9;
      9'h015: id = 6'd10;  9'h01D: id = 6'd11;  9'h024: id = 6'd12;  9'h02D: id = 6'd13;  9'h02C: id = 6'd14;
      9'h016: id = 6'd15;  9'h01E: id = 6'd16;  9'h026: id = 6'd17;  9'h025: id = 6'd18;  9'h02E: id = 6'd19;
      9'h045: id = 6'd20;  9'h046: id = 6'd21;  9'h03E: id = 6'd22;  9'h03D: id = 6'd23;  9'h036: id = 6'd24;
      9'h04D: id = 6'd25;  9'h044: id = 6'd26;  9'h043: id = 6'd27;  9'h03C: id = 6'd28;  9'h035: id = 6'd29;
      9'h05A: id = 6'd30;  9'h04B: id = 6'd31;  9'h042: id = 6'd32;  9'h03B: id = 6'd33;  9'h033: id = 6'd34;
      9'h029: id = 6'd35;  9'h059: id = 6'd36;  9'h03A: id = 6'd37;  9'h031: id = 6'd38;  9'h032: id = 6'd39;
      9'h066: id = 6'd40;  9'h16B: id = 6'd41;  9'h172: id = 6'd42;  9'h175: id = 6'd43;  9'h174: id = 6'd44;
      9'h005: id = 6'd45;  9'h006: id = 6'd46;  9'h004: id = 6'd47;  9'h00C: id = 6'd48;  9'h003: id = 6'd49;
      9'h00B: id = 6'd50;  9'h083: id = 6'd51;  9'h00A: id = 6'd52;  9'h001: id = 6'd53;  9'h009: id = 6'd54;
      9'h078: id = 6'd55;
      9'h014: id = 6'd56;  9'h114: id = 6'd57;  9'h011: id = 6'd58;  9'h111: id = 6'd59;
      default: hit = 1'b0;
    endcase
    return {hit, id};
  endfunction

  // Decoder: prefix flags and held-key flags
  logic [NKEYS-1:0] keys;
  logic             ext_flag, rel_flag;
  logic [6:0]       lk;

  assign lk = key_lookup({ext_flag, shreg});

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      keys     <= '0;
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
    end else if (byte_valid) begin
      case (shreg)
        8'hE0: ext_flag <= 1'b1;
        8'hF0: rel_flag <= 1'b1;
        8'h00, 8'hFF: begin
          keys     <= '0;
          ext_flag <= 1'b0;
          rel_flag <= 1'b0;
        end
        8'hAA, 8'hFC: ;   // self-test / error replies leave prefixes intact
        default: begin
          for (int i = 0; i < NKEYS; i++) begin
            if (lk[6] && (lk[5:0] == 6'(i))) keys[i] <= ~rel_flag;
          end
          ext_flag <= 1'b0;
          rel_flag <= 1'b0;
        end
      endcase
    end
  end

  // Matrix: composites keep their own flags and are ORed in, so releasing
  // a cursor key never drops a Caps Shift that is physically held.
  logic [7:0][4:0] mtx;
  logic [4:0]      col;
  logic            unused_addr;

  assign unused_addr = ^addr[7:0];

  always_comb begin
    mtx       = keys[39:0];
    mtx[0][0] = mtx[0][0] | keys[K_BS] | keys[K_LEFT] | keys[K_DOWN] | keys[K_UP] | keys[K_RIGHT];
    mtx[4][0] = mtx[4][0] | keys[K_BS];
    mtx[3][4] = mtx[3][4] | keys[K_LEFT];
    mtx[4][4] = mtx[4][4] | keys[K_DOWN];
    mtx[4][3] = mtx[4][3] | keys[K_UP];
    mtx[4][2] = mtx[4][2] | keys[K_RIGHT];
    col = '0;
    for (int r = 0; r < 8; r++) begin
      if (!addr[8 + r]) col = col | mtx[r];
    end
    key_data = ~col;
  end

  assign Fn  = keys[K_F1 + 10:K_F1];
  assign mod = {keys[K_CS] | keys[K_SS],
                keys[K_LALT] | keys[K_RALT],
                keys[K_LCTRL] | keys[K_RCTRL]};

endmodule

// File: tb/tb_zx_ps2_keyboard.sv
module tb_zx_ps2_keyboard;

  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int HALF = 14;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ps2_kbd_clk = 1'b1;
  logic        ps2_kbd_data = 1'b1;
  logic [15:0] addr = 16'hFFFF;
  logic [4:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;

  always #5 clk_sys = ~clk_sys;

  zx_ps2_keyboard #(.FILTER(FILT), .TIMEOUT(TMO)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .addr         (addr),
    .key_data     (key_data),
    .Fn           (Fn),
    .mod          (mod)
  );

  // ---------------- reference model ----------------
  int rows_tab [8][5] = '{'{'h12,'h1A,'h22,'h21,'h2A}, '{'h1C,'h1B,'h23,'h2B,'h34},
                          '{'h15,'h1D,'h24,'h2D,'h2C}, '{'h16,'h1E,'h26,'h25,'h2E},
                          '{'h45,'h46,'h3E,'h3D,'h36}, '{'h4D,'h44,'h43,'h3C,'h35},
                          '{'h5A,'h4B,'h42,'h3B,'h33}, '{'h29,'h59,'h3A,'h31,'h32}};
  int fcode [11] = '{'h05,'h06,'h04,'h0C,'h03,'h0B,'h83,'h0A,'h01,'h09,'h78};
  int ext_pool [6] = '{'h6B,'h72,'h75,'h74,'h14,'h11};
  int misc_pool [5] = '{'h66,'h14,'h11,'h0E,'h12};

  bit held [512];
  bit m_ext, m_rel;

  function automatic bit maps(int k, int r, int b);
    bit cs;
    if (k == rows_tab[r][b]) return 1'b1;
    cs = (r == 0 && b == 0);
    case (k)
      'h066: return cs || (r == 4 && b == 0);
      'h16B: return cs || (r == 3 && b == 4);
      'h172: return cs || (r == 4 && b == 4);
      'h175: return cs || (r == 4 && b == 3);
      'h174: return cs || (r == 4 && b == 2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_mapped(int k);
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 5; b++)
        if (rows_tab[r][b] == k) return 1'b1;
    for (int i = 0; i < 11; i++)
      if (fcode[i] == k) return 1'b1;
    case (k)
      'h066, 'h16B, 'h172, 'h175, 'h174, 'h014, 'h114, 'h011, 'h111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) held[i] = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) model_clear();
    else if (b == 8'hAA || b == 8'hFC) begin end
    else begin
      k = (m_ext ? 256 : 0) + int'(b);
      if (is_mapped(k)) held[k] = !m_rel;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  function automatic logic [4:0] exp_kd(input logic [15:0] a);
    logic [4:0] kd;
    kd = 5'h1F;
    for (int k = 0; k < 512; k++)
      if (held[k])
        for (int r = 0; r < 8; r++)
          if (!a[8 + r])
            for (int b = 0; b < 5; b++)
              if (maps(k, r, b)) kd[b] = 1'b0;
    return kd;
  endfunction

  function automatic logic [11:1] exp_fn();
    logic [11:1] f;
    for (int i = 0; i < 11; i++) f[i + 1] = held[fcode[i]];
    return f;
  endfunction

  function automatic logic [2:0] exp_mod();
    return {held['h012] | held['h059], held['h011] | held['h111], held['h014] | held['h114]};
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [4:0]  q_kd  [$];
  logic [11:1] q_fn  [$];
  logic [2:0]  q_mod [$];
  string       q_tag [$];

  initial begin : monitor
    logic [4:0]  kd;
    logic [11:1] fn;
    logic [2:0]  md;
    string       tag;
    forever begin
      @(negedge clk_sys);
      if (q_kd.size() > 0) begin
        kd  = q_kd.pop_front();
        fn  = q_fn.pop_front();
        md  = q_mod.pop_front();
        tag = q_tag.pop_front();
        checks++;
        if (key_data === kd) passed++;
        else $display("FAIL %s key_data got %h want %h", tag, key_data, kd);
        checks++;
        if (Fn === fn) passed++;
        else $display("FAIL %s Fn got %h want %h", tag, Fn, fn);
        checks++;
        if (mod === md) passed++;
        else $display("FAIL %s mod got %b want %b", tag, mod, md);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_at(input logic [15:0] a, input string tag);
    int n;
    addr = a;
    #1;
    q_kd.push_back(exp_kd(a));
    q_fn.push_back(exp_fn());
    q_mod.push_back(exp_mod());
    q_tag.push_back(tag);
    n = 0;
    while (q_kd.size() != 0 && n < 8) begin
      @(posedge clk_sys);
      n++;
    end
    #1;
    if (q_kd.size() != 0) begin
      checks++;
      $display("FAIL %s monitor did not consume expectation", tag);
      q_kd.delete(); q_fn.delete(); q_mod.delete(); q_tag.delete();
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_kbd_data = v;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b0;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_kbd_data = 1'b1;
    wait_cyc(HALF + 4);
  endtask

  task automatic send(input logic [7:0] b);
    send_raw(b, 1'b0);
    model_byte(b);
  endtask

  initial begin : stim
    int c, code;
    bit ext, rel;
    logic [15:0] a;
    model_clear();
    #1 reset_n = 1'b0;
    wait_cyc(4);
    expect_at(16'h0000, "reset");
    reset_n = 1'b1;
    wait_cyc(5);

    send(8'h1C);
    expect_at(16'hFDFE, "make_a");
    expect_at(16'hFEFE, "row0_a");
    send(8'hF0); send(8'h1C);
    expect_at(16'hFDFE, "break_a");
    expect_at(16'hFEFE, "row0_brk");

    send(8'h12); send(8'h66);
    expect_at(16'hFEFE, "cs_bs");
    expect_at(16'hEFFE, "zero_bs");
    send(8'hF0); send(8'h66);
    expect_at(16'hFEFE, "cs_held");
    expect_at(16'hEFFE, "zero_rel");
    send(8'hF0); send(8'h12);

    send(8'h14); send(8'h78);
    expect_at(16'hFFFF, "ctrl_f11");
    send(8'hF0); send(8'h78);
    expect_at(16'hFFFF, "f11_rel");
    send(8'hE0); send(8'hF0); send(8'h14);
    expect_at(16'h0000, "rctrl_rel");

    send_raw(8'h1C, 1'b1);
    expect_at(16'hFDFE, "bad_par");
    send(8'h29);
    expect_at(16'h7FFE, "space");

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    wait_cyc(TMO + 10);
    send(8'h5A);
    expect_at(16'hBFFE, "enter_after_to");

    ps2_bit(1'b0); ps2_bit(1'b1);
    reset_n = 1'b0;
    model_clear();
    wait_cyc(3);
    expect_at(16'h0000, "reset_mid");
    reset_n = 1'b1;
    wait_cyc(5);
    send(8'h1C);
    expect_at(16'hFDFE, "after_reset");

    send(8'h29); send(8'h14); send(8'h05);
    expect_at(16'h0000, "pre_clear");
    send(8'h00);
    expect_at(16'h0000, "overrun");

    ps2_kbd_data = 1'b0;
    wait_cyc(3);
    ps2_kbd_clk = 1'b0;
    wait_cyc(1);
    ps2_kbd_clk = 1'b1;
    wait_cyc(20);
    ps2_kbd_data = 1'b1;
    wait_cyc(5);
    send(8'h29);
    expect_at(16'h7FFE, "glitch");

    send(8'hE0); send(8'hAA); send(8'h75);
    expect_at(16'h0000, "aa_keeps_ext");

    for (int it = 0; it < 60; it++) begin
      c = $urandom_range(0, 9);
      rel = ($urandom_range(0, 2) == 0);
      ext = 1'b0;
      code = 0;
      case (c)
        5: code = fcode[$urandom_range(0, 10)];
        6: begin code = ext_pool[$urandom_range(0, 5)]; ext = 1'b1; end
        7: code = misc_pool[$urandom_range(0, 4)];
        default: code = rows_tab[$urandom_range(0, 7)][$urandom_range(0, 4)];
      endcase
      if (c == 8) begin
        if ($urandom_range(0, 3) == 0) send(8'h00);
        else send(8'hAA);
      end else if (c == 9) begin
        send_raw(8'(code), 1'b1);
      end else begin
        if (ext) send(8'hE0);
        if (rel) send(8'hF0);
        send(8'(code));
      end
      a = 16'($urandom);
      if ($urandom_range(0, 2) == 0) a[15:8] = ~(8'd1 << $urandom_range(0, 7));
      expect_at(a, "random");
    end

    wait_cyc(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/zx_ps2_keyboard.md
Name: zx_ps2_keyboard

Overview:
PS/2 keyboard front end for the Spectrum host board. It receives raw PS/2 frames, decodes scan-code set 2 into a held-key state and maps that state onto the 8x5 ZX keyboard matrix. The CPU reads the matrix through port FE, selecting half-rows with addr[15:8]. The block also exports F1..F11 levels and modifier levels to the turbo, reset, tape and esxDOS control logic.

Parameters:
FILTER, 8, consecutive equal samples required to accept a ps2_kbd_clk level change.
TIMEOUT, 65535, clk_sys cycles without a falling edge before a partial frame is discarded.

Ports:
clk_sys  in  1  system clock; all state on posedge.
reset_n  in  1  asynchronous active-low reset.
ps2_kbd_clk  in  1  PS/2 clock, asynchronous.
ps2_kbd_data  in  1  PS/2 data, asynchronous.
addr  in  16  CPU address; addr[15:8] are the half-row selects, active low.
key_data  out  5  matrix column read, active low, bit0 = outermost key.
Fn  out  11  Fn[k] = 1 while Fk is held (k = 1..11).
mod  out  3  [0] Ctrl held, [1] Alt held, [2] Shift (either) held.

Behaviour:
- Reset: all key flags cleared; key_data=5'h1F, Fn=0, mod=0; receiver in IDLE; prefix flags cleared. Reset is asynchronous on assertion and synchronous on release.
- Input conditioning:
  - Both PS/2 lines pass through 2-FF synchronisers.
  - The clock line then passes a FILTER-cycle glitch filter.
  - Falling edge = filtered clock goes 1->0. Data is sampled on that edge.
- Receiver FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 -> DATA, bit count 0. An edge with data=1 is ignored.
  - DATA: shift in LSB-first; after the 8th bit -> PARITY.
  - PARITY: record the bit -> STOP.
  - STOP: if data=1 and odd parity over 9 bits holds, pulse byte_valid for 1 cycle; -> IDLE in all cases. A bad stop or parity bit discards the byte silently.
  - Timeout counter resets on every edge. When it reaches TIMEOUT in a non-IDLE state -> IDLE and the partial byte is dropped.
- Decoder, acting on byte_valid:
  - E0 sets the ext flag. F0 sets the rel flag.
  - Any other byte applies press (rel=0) or release (rel=1) to the key identified by {ext, code}, then clears both flags.
  - E0 F0 xx is an extended release.
  - 00 or FF (overrun) clears all key flags and both prefix flags.
  - AA and FC are ignored and leave the flags unchanged.
  - Unmapped codes are consumed: flags are cleared and no state change occurs.
- Key state: one flag per physical key. Repeated make codes are idempotent.
- Matrix is updated on the cycle after byte_valid; key_data is combinational from the flags. Latency from stop-bit edge to key_data is 2 cycles.
- Matrix rows (row r selected when addr[8+r]=0; columns bit0..4):
  - r0: CS Z X C V
  - r1: A S D F G
  - r2: Q W E R T
  - r3: 1 2 3 4 5
  - r4: 0 9 8 7 6
  - r5: P O I U Y
  - r6: Enter L K J H
  - r7: Space SS M N B
- Key mapping:
  - CS = LShift (12).
  - SS = RShift (59).
  - Letters, digits, Enter (5A) and Space (29) map directly.
- Composite keys use their own flags, ORed into the matrix, so releasing one never clears a physically held CS:
  - Backspace (66) = CS+0.
  - E0 6B left = CS+5.
  - E0 72 down = CS+6.
  - E0 75 up = CS+7.
  - E0 74 right = CS+8.
- key_data[b] = ~OR over selected rows of matrix[r][b]. With no row selected, key_data = 1F. With several rows selected, their columns are ORed.
- Fn from codes:
  - F1=05, F2=06, F3=04, F4=0C, F5=03, F6=0B, F7=83, F8=0A, F9=01, F10=09, F11=78.
  - Fn holds a level, not a pulse.
- mod:
  - [0] = LCtrl 14 | RCtrl E0 14.
  - [1] = LAlt 11 | RAlt E0 11.
  - [2] = LShift | RShift.
- Reset mid-frame: the receiver returns to IDLE and the next start bit is received correctly.

Test Plan:
- Send frames 1C, then F0 1C, with addr=FDFE -> key_data=1E after the make, 1F after the break. With addr=FEFE -> 1F throughout.
- Send 12 then 66, read addr=FEFE/EFFE -> 1E/1E. Send F0 66 -> FEFE still reads 1E (Shift held), EFFE reads 1F.
- Send 14 then 78 -> mod=3'b001 and Fn[11]=1. Send F0 78 -> Fn=0 with mod unchanged. Send E0 F0 14 with LCtrl held -> mod[0] stays 1.
- Send a 1C frame with a flipped parity bit -> no state change. Then a valid 29, read addr=7FFE -> key_data=1E.
- Send a 4-bit partial frame, wait TIMEOUT+10 cycles, then a valid 5A, read addr=BFFE -> key_data=1E. Pulse reset_n low mid-frame -> all outputs at reset values and the next frame decodes.
- Hold 1C and 29, send 00 -> key_data=1F with addr=0000, Fn=0, mod=0. A 1-cycle glitch on ps2_kbd_clk produces no bit.
